// File: rtl/sd_cmd_controller_pkg.sv
// SD command controller shared types and constants.
// Frame layout, CRC7 polynomial and FSM state encoding.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    RECV,
    FINISH
  } state_t;

  localparam int FRAME_BITS = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int START   = 47;
  localparam int HOST    = 46;
  localparam int IDX_MSB = 45;
  localparam int ARG_MSB = 39;
  localparam int CRC_MSB = 7;
  localparam int END     = 0;

endpackage

// File: rtl/sd_cmd_controller_if.sv
// Host/pad bundle for the SD command controller.
// master = host logic and pad, slave = the controller.
interface sd_cmd_controller_if;

  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] argument;
  logic        resp_expected;
  logic        cmd_in;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;
  logic [47:0] response;
  logic        timeout;
  logic        crc_err;

  modport master (
    output start, cmd_index, argument,
    output resp_expected, cmd_in,
    input  cmd_out, cmd_oe, busy, done,
    input  response, timeout, crc_err
  );

  modport slave (
    input  start, cmd_index, argument,
    input  resp_expected, cmd_in,
    output cmd_out, cmd_oe, busy, done,
    output response, timeout, crc_err
  );

endinterface

// File: rtl/sd_cmd_controller_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first.
// Shared by the TX and RX paths, which never overlap.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  logic w_fb;

  assign w_fb = crc[6] ^ din;

  // shift one bit per enabled cycle; clear wins
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^
             (w_fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_controller.sv
// SD CMD-line transaction sequencer: send a
// 48-bit command, optionally capture a response.
module sd_cmd_controller
  import sd_cmd_pkg::*;
#(
  parameter int NCR_MAX  = 64,
  parameter int NCR_BITS = 7
) (
  input  logic clk,
  input  logic reset,
  sd_cmd_controller_if.slave bus
);

  state_t                r_state;
  logic [5:0]            r_cnt;
  logic                  r_tx_last;
  logic [5:0]            r_idx;
  logic [31:0]           r_arg;
  logic                  r_resp_exp;
  logic [NCR_BITS-1:0]   r_ncr;
  logic                  r_cmd_out;
  logic                  r_cmd_oe;
  logic                  r_busy;
  logic                  r_done;
  logic [47:0]           r_response;
  logic                  r_timeout;
  logic                  r_crc_err;

  logic [6:0]            w_crc;
  logic                  w_crc_clr;
  logic                  w_crc_en;
  logic                  w_crc_din;
  logic                  w_tx_bit;
  logic [39:0]           w_hdr;
  logic [5:0]            w_hdr_idx;
  logic [2:0]            w_crc_idx;

  sd_crc7 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_crc_clr),
    .enable (w_crc_en),
    .din    (w_crc_din),
    .crc    (w_crc)
  );

  // frame bit selected by the down-counter
  always_comb begin
    w_hdr     = {1'b0, 1'b1, r_idx, r_arg};
    w_hdr_idx = r_cnt - 6'(CRC_MSB + 1);
    w_crc_idx = 3'(r_cnt - 6'd1);
    w_tx_bit  = 1'b1;
    if (r_cnt > 6'(CRC_MSB)) begin
      w_tx_bit = w_hdr[w_hdr_idx];
    end else if (r_cnt != 6'(END)) begin
      w_tx_bit = w_crc[w_crc_idx];
    end
  end

  // CRC feed: TX header bits, then RX bits
  always_comb begin
    w_crc_clr = 1'b0;
    w_crc_en  = 1'b0;
    w_crc_din = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_crc_clr = bus.start;
      end
      SEND: begin
        w_crc_clr = r_tx_last;
        w_crc_en  = !r_tx_last &&
                    (r_cnt > 6'(CRC_MSB));
        w_crc_din = w_tx_bit;
      end
      WAIT_RESP: begin
        w_crc_en  = !bus.cmd_in;
        w_crc_din = bus.cmd_in;
      end
      RECV: begin
        w_crc_en  = r_cnt > 6'(CRC_MSB);
        w_crc_din = bus.cmd_in;
      end
      default: begin
        w_crc_clr = 1'b0;
      end
    endcase
  end

  // transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tx_last  <= 1'b0;
      r_idx      <= '0;
      r_arg      <= '0;
      r_resp_exp <= 1'b0;
      r_ncr      <= '0;
      r_cmd_out  <= 1'b1;
      r_cmd_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_response <= '0;
      r_timeout  <= 1'b0;
      r_crc_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_idx      <= bus.cmd_index;
            r_arg      <= bus.argument;
            r_resp_exp <= bus.resp_expected;
            r_timeout  <= 1'b0;
            r_crc_err  <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= 6'(START);
            r_tx_last  <= 1'b0;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (!r_tx_last) begin
            r_cmd_out <= w_tx_bit;
            r_cmd_oe  <= 1'b1;
            if (r_cnt == 6'(END)) begin
              r_tx_last <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end else begin
            r_cmd_out <= 1'b1;
            r_cmd_oe  <= 1'b0;
            r_tx_last <= 1'b0;
            r_ncr     <= '0;
            r_state   <= r_resp_exp ?
                         WAIT_RESP : FINISH;
          end
        end
        WAIT_RESP: begin
          if (!bus.cmd_in) begin
            r_response[START] <= 1'b0;
            r_cnt   <= 6'(HOST);
            r_state <= RECV;
          end else if (r_ncr ==
                       NCR_BITS'(NCR_MAX - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= FINISH;
          end else begin
            r_ncr <= r_ncr + 1'b1;
          end
        end
        RECV: begin
          r_response[r_cnt] <= bus.cmd_in;
          if (r_cnt == 6'(END)) begin
            r_crc_err <= (r_response[7:1] != w_crc) |
                         !bus.cmd_in;
            r_state   <= FINISH;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_out  = r_cmd_out;
  assign bus.cmd_oe   = r_cmd_oe;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.response = r_response;
  assign bus.timeout  = r_timeout;
  assign bus.crc_err  = r_crc_err;

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Bench for sd_cmd_controller: directed + random
// transactions against a polynomial-division model.
module tb_sd_cmd_controller;

  localparam int NCR_MAX = 64;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sd_cmd_controller_if bus ();

  sd_cmd_controller #(
    .NCR_MAX  (NCR_MAX),
    .NCR_BITS (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [47:0] prev_resp;
  logic [47:0] cap_frame;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [46:0] v;
    v = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [47:0] mkframe(input logic [5:0] idx,
                                          input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  function automatic logic [47:0] mkresp(input logic [5:0] idx,
                                         input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b00, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one transaction; card drives word starting dly cycles after end bit
  task automatic run_txn(input logic [5:0] idx,
                         input logic [31:0] arg,
                         input bit rexp,
                         input bit card,
                         input int dly,
                         input logic [47:0] word,
                         input bit poke);
    int k, j, oe_n, oe_first, oe_last;
    int done_n, done_k, to_k, exp_done;
    logic [47:0] fr, exp_resp;
    bit exp_err;
    bus.cmd_index     = idx;
    bus.argument      = arg;
    bus.resp_expected = rexp;
    bus.start         = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0; oe_n = 0; oe_first = 0; oe_last = 0;
    done_n = 0; done_k = 0; to_k = 0; fr = '0;
    do begin
      tick();
      k++;
      if (k == 1) chk("busy_on", bus.busy, 1);
      if (bus.cmd_oe) begin
        fr = {fr[46:0], bus.cmd_out};
        oe_n++;
        if (oe_first == 0) oe_first = k;
        oe_last = k;
      end
      if (bus.done) begin
        done_n++;
        done_k = k;
      end
      if (bus.timeout && to_k == 0) to_k = k;
      j = 95 + dly - k;
      bus.cmd_in = (card && j >= 0 && j <= 47) ?
                   word[j] : 1'b1;
      bus.start = poke && (k == 20 || (rexp && k == 50));
      bus.cmd_index = poke ? ~idx : idx;
    end while (k < 250 && !(done_k > 0 && k > done_k));
    bus.start = 1'b0;
    bus.cmd_in = 1'b1;
    if (card)      exp_done = 97 + dly;
    else if (rexp) exp_done = 50 + NCR_MAX;
    else           exp_done = 50;
    exp_resp = card ? word : prev_resp;
    exp_err  = card && ((crc7(word[47:8]) != word[7:1]) ||
                        !word[0]);
    chk("frame", fr, mkframe(idx, arg));
    chk("oe_cycles", oe_n, 48);
    chk("oe_first", oe_first, 1);
    chk("oe_last", oe_last, 48);
    chk("done_count", done_n, 1);
    chk("done_cycle", done_k, exp_done);
    chk("timeout", bus.timeout, rexp && !card);
    chk("timeout_cycle", to_k,
        (rexp && !card) ? 49 + NCR_MAX : 0);
    chk("response", bus.response, exp_resp);
    chk("crc_err", bus.crc_err, exp_err);
    chk("busy_off", bus.busy, 0);
    prev_resp = exp_resp;
    cap_frame = fr;
  endtask

  initial begin
    logic [47:0] w;
    logic [5:0]  ri;
    logic [31:0] ra;
    bit          re, rc;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cmd_in = 1'b1;
    bus.cmd_index = '0;
    bus.argument = '0;
    bus.resp_expected = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_out", bus.cmd_out, 1);
    chk("rst_cmd_oe", bus.cmd_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_response", bus.response, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_crc_err", bus.crc_err, 0);
    reset = 1'b0;
    tick();
    prev_resp = '0;

    run_txn(6'd0, 32'h0, 0, 0, 0, 48'h0, 0);
    chk("cmd0_frame", cap_frame, 48'h400000000095);

    w = 48'h08000001AA13;
    run_txn(6'd8, 32'h1AA, 1, 1, 5, w, 0);
    chk("cmd8_frame", cap_frame, 48'h48000001AA87);
    chk("cmd8_resp", bus.response, 48'h08000001AA13);
    chk("cmd8_crc_ok", bus.crc_err, 0);

    w = 48'h08000001AA13 ^ (48'h1 << 20);
    run_txn(6'd8, 32'h1AA, 1, 1, 5, w, 0);
    chk("cmd8_flip_err", bus.crc_err, 1);

    run_txn(6'd17, 32'h0, 1, 0, 0, 48'h0, 0);
    run_txn(6'd8, 32'h1AA, 1, 1, 10,
            mkresp(6'd8, 32'h1AA), 1);
    run_txn(6'd17, 32'h1234, 1, 0, 0, 48'h0, 1);
    run_txn(6'd0, 32'h0, 0, 0, 0, 48'h0, 1);

    bus.cmd_index = 6'd0;
    bus.argument = 32'h0;
    bus.resp_expected = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (18) tick();
    chk("mid_oe", bus.cmd_oe, 1);
    reset = 1'b1;
    tick();
    chk("abort_oe", bus.cmd_oe, 0);
    chk("abort_out", bus.cmd_out, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    reset = 1'b0;
    tick();
    chk("abort_nodone", bus.done, 0);
    prev_resp = '0;
    run_txn(6'd0, 32'h0, 0, 0, 0, 48'h0, 0);
    chk("cmd0_after_rst", cap_frame, 48'h400000000095);

    for (int t = 0; t < 10; t++) begin
      ri = 6'($urandom);
      ra = $urandom;
      re = 1'($urandom);
      rc = re && ($urandom_range(0, 3) != 0);
      w = mkresp(6'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0)
        w = w ^ (48'h1 << $urandom_range(0, 46));
      run_txn(ri, ra, re, rc,
              $urandom_range(1, NCR_MAX), w,
              1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_controller.md
Name: sd_cmd_controller

Overview:
Sequences one SD command transaction on the CMD line. It builds the 48-bit command frame (start, host bit, index, argument, CRC7, end) and shifts it out MSB-first. It then optionally waits for and captures a 48-bit short response, checking its CRC7. It sits between the host command logic and the CMD pad, and owns cmd_oe.

Parameters:
NCR_MAX, 64, max clocks after command end bit to wait for a response start bit before timeout
NCR_BITS, 7, width of the NCR wait counter; must hold NCR_MAX

Ports:
clk  input  1  system clock; the CMD line is driven and sampled on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only when busy=0
cmd_index  input  6  command index, latched on accept
argument  input  32  command argument, latched on accept
resp_expected  input  1  1 = wait for a 48-bit response, 0 = no response; latched on accept
cmd_in  input  1  sampled CMD line from the card
cmd_out  output  1  serial CMD data to the pad; idles at 1
cmd_oe  output  1  pad output enable; 1 only while sending a frame
busy  output  1  transaction in progress
done  output  1  one-cycle pulse when the transaction ends
response  output  48  captured response frame, MSB = first bit received
timeout  output  1  status: no response start bit within NCR_MAX
crc_err  output  1  status: response CRC7 mismatch, or end bit is 0

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE, cmd_out=1, cmd_oe=0, busy=0, done=0, response=0, timeout=0, crc_err=0. Reset asserted mid-transaction aborts on the next edge with these values and no done pulse.
- Frame format, bits 47..0:
  - bit 47 = 0 (start)
  - bit 46 = 1 (host)
  - bits 45:40 = cmd_index
  - bits 39:8 = argument
  - bits 7:1 = CRC7
  - bit 0 = 1 (end)
- CRC7: polynomial x^7+x^3+1, register initialised to 0, computed serially over bits 47..8.
  - fb = crc[6] ^ din
  - crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 0)
- States: IDLE, SEND, WAIT_RESP, RECV, FINISH.
- IDLE:
  - If start=1: latch the inputs, clear timeout and crc_err, clear the CRC, set busy=1 on the next edge, go to SEND with bit counter=47.
- SEND:
  - Each cycle, cmd_out and cmd_oe are registered; frame bit[cnt] appears on cmd_out one cycle after the accept edge.
  - Exactly 48 consecutive cycles with cmd_oe=1.
  - CRC is updated for cnt 47..8; bits 7..1 are taken from the CRC register MSB-first.
  - After bit 0, cmd_oe=0 and cmd_out=1. Go to WAIT_RESP if resp_expected=1, else FINISH.
- WAIT_RESP:
  - Clear the CRC and the NCR counter; increment the counter each cycle.
  - cmd_in=0 sampled → response bit 47=0, go to RECV with cnt=46, feeding the CRC with 0.
  - Counter reaching NCR_MAX with no start bit → timeout=1, go to FINISH.
- RECV:
  - Shift cmd_in into response[cnt] and decrement cnt; 47 cycles total.
  - CRC is fed for bits 46..8.
  - After bit 0: crc_err = (received bits 7:1 != computed CRC) | (bit 0 == 0). Go to FINISH.
- FINISH: done=1 for one cycle, busy=0 on the next edge, return to IDLE.
- Hold rules:
  - response, timeout and crc_err hold until the next accepted start.
  - start while busy=1 is ignored and not queued.
- Latency: the no-response transaction is 50 cycles from the accept edge to done high.

Decomposition:
- Package sd_cmd_pkg:
  - state enumeration
  - FRAME_BITS=48
  - CRC7_POLY=7'h09
  - bit-position constants: START=47, HOST=46, IDX_MSB=45, ARG_MSB=39, CRC_MSB=7, END=0
- Sub-module sd_crc7:
  - ports clk, reset, clear, enable, din, crc[6:0]
  - one instance, shared by TX and RX since they never overlap.

Test Plan:
- CMD0, argument 0, resp_expected=0 → cmd_out sequence over 48 cycles is 0x400000000095 (CRC 0x4A). cmd_oe high exactly 48 cycles, done 1 cycle later, timeout=0.
- CMD8, argument 0x000001AA, resp_expected=1; card drives 0x08000001AA13 starting 5 cycles after the end bit → frame sent is 0x48000001AA87, response=0x08000001AA13, crc_err=0, timeout=0.
- CMD8 as above, but the card flips response bit 20 → response captured with bit 20 flipped, crc_err=1, done pulses.
- CMD17, argument 0, resp_expected=1, cmd_in held at 1 → frame 0x510000000055, timeout=1 exactly NCR_MAX cycles after the end bit, done pulses, response unchanged.
- start pulsed again during SEND, and during WAIT_RESP → ignored; the transaction's frame and timing are unchanged.
- reset asserted at bit 30 of SEND → next edge: cmd_oe=0, cmd_out=1, busy=0, no done. A subsequent CMD0 start produces 0x400000000095 correctly.
